// File: rtl/updown_limit_counter.sv
// Up/down counter bounded by a runtime LIMIT with wrap or (UPDOWN_LIMIT_COUNTER_SAT_EN) saturate at the bounds.
// Latency: COUNT and triggers are registered (1 cycle); AT_LIMIT/AT_ZERO are combinational.
// Backpressure: none; ENABLE gates one step per cycle, LOAD and RESET take priority.
module updown_limit_counter #(
    parameter int COUNTER_WIDTH = 8,
    parameter int RESET_VALUE   = 0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     ENABLE,
    input  logic                     UP,
    input  logic                     LOAD,
    input  logic [COUNTER_WIDTH-1:0] LOAD_VALUE,
    input  logic [COUNTER_WIDTH-1:0] LIMIT,
    input  logic                     SAT,
    output logic [COUNTER_WIDTH-1:0] COUNT,
    output logic                     TRIG_OUT,
    output logic                     TRIG_UNDER,
    output logic                     AT_LIMIT,
    output logic                     AT_ZERO
);

    localparam logic [COUNTER_WIDTH-1:0] RST_COUNT = COUNTER_WIDTH'(RESET_VALUE);
    localparam logic [COUNTER_WIDTH-1:0] ONE       = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] ZERO      = '0;

    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic                     trig_out_q, trig_out_d;
    logic                     trig_under_q, trig_under_d;
    logic                     sat_w;

`ifdef UPDOWN_LIMIT_COUNTER_SAT_EN
    assign sat_w = SAT;
`else
    // Wrap-only build: SAT is kept on the port list for pin compatibility.
    logic unused_sat;
    assign unused_sat = SAT;
    assign sat_w      = 1'b0;
`endif

    always_comb begin
        count_d      = count_q;
        trig_out_d   = 1'b0;
        trig_under_d = 1'b0;
        if (LOAD) begin
            count_d = (LOAD_VALUE > LIMIT) ? LIMIT : LOAD_VALUE;
        end else if (ENABLE && UP) begin
            if (count_q < LIMIT) begin
                count_d = count_q + ONE;
            end else begin
                count_d    = sat_w ? LIMIT : ZERO;
                trig_out_d = 1'b1;
            end
        end else if (ENABLE) begin
            // A count left above a lowered LIMIT snaps back without a trigger.
            if (count_q > LIMIT) begin
                count_d = LIMIT;
            end else if (count_q == ZERO) begin
                count_d      = sat_w ? ZERO : LIMIT;
                trig_under_d = 1'b1;
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q      <= RST_COUNT;
            trig_out_q   <= 1'b0;
            trig_under_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            trig_out_q   <= trig_out_d;
            trig_under_q <= trig_under_d;
        end
    end

    assign COUNT      = count_q;
    assign TRIG_OUT   = trig_out_q;
    assign TRIG_UNDER = trig_under_q;
    assign AT_LIMIT   = (count_q >= LIMIT);
    assign AT_ZERO    = (count_q == ZERO);

endmodule

// File: tb/tb_updown_limit_counter.sv
// Bench for updown_limit_counter: integer reference model checked every cycle, directed literal scenarios, random phase.
module tb_updown_limit_counter;

    localparam int W  = 4;
    localparam int RV = 2;

    logic         CLK;
    logic         RESET, ENABLE, UP, LOAD, SAT;
    logic [W-1:0] LOAD_VALUE, LIMIT;
    logic [W-1:0] COUNT;
    logic         TRIG_OUT, TRIG_UNDER, AT_LIMIT, AT_ZERO;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_count  = 0;
    bit m_to     = 0;
    bit m_tu     = 0;
    bit m_valid  = 0;

    updown_limit_counter #(.COUNTER_WIDTH(W), .RESET_VALUE(RV)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .UP(UP), .LOAD(LOAD),
        .LOAD_VALUE(LOAD_VALUE), .LIMIT(LIMIT), .SAT(SAT),
        .COUNT(COUNT), .TRIG_OUT(TRIG_OUT), .TRIG_UNDER(TRIG_UNDER),
        .AT_LIMIT(AT_LIMIT), .AT_ZERO(AT_ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit sat_on(input logic s);
`ifdef UPDOWN_LIMIT_COUNTER_SAT_EN
        return s;
`else
        return 1'b0;
`endif
    endfunction

    // Model: the spec's rules applied to plain integers at each rising edge.
    always @(posedge CLK) begin
        int lim, lv;
        lim = int'(LIMIT);
        lv  = int'(LOAD_VALUE);
        if (RESET) begin
            m_count = RV % (1 << W);
            m_to = 0; m_tu = 0; m_valid = 1;
        end else if (LOAD) begin
            m_count = (lv < lim) ? lv : lim;
            m_to = 0; m_tu = 0;
        end else if (ENABLE && UP) begin
            m_tu = 0;
            if (m_count < lim) begin m_count = m_count + 1; m_to = 0; end
            else begin m_to = 1; m_count = sat_on(SAT) ? lim : 0; end
        end else if (ENABLE) begin
            m_to = 0;
            if (m_count > lim) begin m_count = lim; m_tu = 0; end
            else if (m_count == 0) begin m_tu = 1; m_count = sat_on(SAT) ? 0 : lim; end
            else begin m_count = m_count - 1; m_tu = 0; end
        end else begin
            m_to = 0; m_tu = 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        if (m_valid) begin
            chk("m_COUNT", 32'(COUNT), 32'(m_count));
            chk("m_TRIG_OUT", 32'(TRIG_OUT), 32'(m_to));
            chk("m_TRIG_UNDER", 32'(TRIG_UNDER), 32'(m_tu));
            chk("m_AT_LIMIT", 32'(AT_LIMIT), 32'(m_count >= int'(LIMIT)));
            chk("m_AT_ZERO", 32'(AT_ZERO), 32'(m_count == 0));
            chk("m_trig_excl", 32'(TRIG_OUT & TRIG_UNDER), 32'd0);
        end
    end

    task automatic drive(input logic rst, input logic ld, input logic en, input logic up,
                         input logic sat, input int lv, input int lim);
        RESET = rst; LOAD = ld; ENABLE = en; UP = up; SAT = sat;
        LOAD_VALUE = W'(lv); LIMIT = W'(lim);
    endtask

    task automatic step();
        @(posedge CLK);
        #3;
    endtask

    task automatic lit(input string nm, input int c, input bit to, input bit tu);
        chk({nm, "_count"}, 32'(COUNT), 32'(c));
        chk({nm, "_trig_out"}, 32'(TRIG_OUT), 32'(to));
        chk({nm, "_trig_under"}, 32'(TRIG_UNDER), 32'(tu));
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 9);
        step();
        lit("reset", RV, 0, 0);

        // Count up through LIMIT=9 and wrap.
        drive(0, 1, 0, 0, 0, 0, 9);
        step();
        lit("load0", 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 9);
        for (int k = 1; k <= 12; k++) begin
            step();
            lit($sformatf("up_wrap%0d", k), k % 10, k == 10, 0);
        end

        // Count down from zero wraps to LIMIT.
        drive(0, 1, 0, 0, 0, 0, 9);
        step();
        drive(0, 0, 1, 0, 0, 0, 9);
        for (int k = 1; k <= 3; k++) begin
            step();
            lit($sformatf("down_wrap%0d", k), 10 - k, 0, k == 1);
        end

        // Hold with ENABLE low.
        drive(0, 0, 0, 1, 0, 0, 9);
        step();
        lit("hold", 7, 0, 0);

        // Up-steps at the bound with SAT set.
        drive(0, 1, 0, 0, 1, 5, 5);
        step();
        lit("load5", 5, 0, 0);
        drive(0, 0, 1, 1, 1, 0, 5);
        for (int k = 1; k <= 3; k++) begin
            step();
`ifdef UPDOWN_LIMIT_COUNTER_SAT_EN
            lit($sformatf("sat_up%0d", k), 5, 1, 0);
`else
            lit($sformatf("sat_up%0d", k), k - 1, k == 1, 0);
`endif
        end

        // Load clamps to LIMIT and overrides ENABLE; lowered LIMIT snaps on a down-step.
        drive(0, 1, 1, 1, 0, 12, 9);
        step();
        lit("load_clamp", 9, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 3);
        #1;
        chk("at_limit_lowered", 32'(AT_LIMIT), 32'd1);
        step();
        lit("lowered_limit", 3, 0, 0);

        // Reset in the same cycle as a qualifying up-step.
        drive(0, 1, 0, 0, 0, 3, 3);
        step();
        drive(1, 0, 1, 1, 0, 0, 3);
        step();
        lit("reset_cancel", RV, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 3);
        step();
        lit("resume", 3, 0, 0);
        step();
        lit("wrap_after_resume", 0, 1, 0);

        // LIMIT == 0: count pinned at zero, both triggers reachable.
        drive(0, 1, 0, 0, 0, 5, 0);
        step();
        lit("lim0_load", 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0, 0);
        step();
        lit("lim0_up", 0, 1, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        step();
        lit("lim0_down", 0, 0, 1);

        // Random phase.
        begin
            int lim;
            lim = 9;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 7) == 0) lim = $urandom_range(0, 15);
                drive($urandom_range(0, 49) == 0, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 15), lim);
                step();
            end
        end

        drive(0, 0, 0, 0, 0, 0, 9);
        step();
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/updown_limit_counter.md
UPDOWN_LIMIT_COUNTER -- requirements
Module: updown_limit_counter

Interface
REQ-001 The module SHALL have parameter COUNTER_WIDTH, default 8, which sets the bit width of the count, LIMIT and LOAD_VALUE.
REQ-002 The module SHALL have parameter RESET_VALUE, default 0, which is the COUNT value after reset (values >= 2^COUNTER_WIDTH are truncated).
REQ-003 Port CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 Port RESET  input  1  reset, synchronous, active-high.
REQ-005 Port ENABLE  input  1  step enable; one step per cycle when high.
REQ-006 Port UP  input  1  direction select: 1 = increment, 0 = decrement.
REQ-007 Port LOAD  input  1  synchronous load strobe.
REQ-008 Port LOAD_VALUE  input  COUNTER_WIDTH  value captured on LOAD.
REQ-009 Port LIMIT  input  COUNTER_WIDTH  runtime upper bound, sampled every cycle.
REQ-010 Port SAT  input  1  1 = saturate at bounds, 0 = wrap at bounds.
REQ-011 Port COUNT  output  COUNTER_WIDTH  current count register.
REQ-012 Port TRIG_OUT  output  1  registered one-cycle pulse on an up-step at the upper bound.
REQ-013 Port TRIG_UNDER  output  1  registered one-cycle pulse on a down-step at zero.
REQ-014 Port AT_LIMIT  output  1  high when COUNT >= LIMIT (combinational from COUNT and LIMIT).
REQ-015 Port AT_ZERO  output  1  high when COUNT == 0 (combinational from COUNT).

Function
REQ-016 Priority SHALL be RESET > LOAD > ENABLE > hold.
REQ-017 LOAD SHALL set COUNT to min(LOAD_VALUE, LIMIT) on the next edge and clear TRIG_OUT and TRIG_UNDER, regardless of ENABLE, UP and SAT.
REQ-018 With ENABLE=1, UP=1, COUNT < LIMIT: COUNT SHALL become COUNT+1 and TRIG_OUT SHALL be 0.
REQ-019 With ENABLE=1, UP=1, COUNT >= LIMIT: COUNT SHALL become 0 if SAT=0, or LIMIT if SAT=1, and TRIG_OUT SHALL be 1 on the following cycle.
REQ-020 With ENABLE=1, UP=0, 0 < COUNT <= LIMIT: COUNT SHALL become COUNT-1 and TRIG_UNDER SHALL be 0.
REQ-021 With ENABLE=1, UP=0, COUNT > LIMIT (LIMIT lowered at runtime): COUNT SHALL become LIMIT and no trigger SHALL fire.
REQ-022 With ENABLE=1, UP=0, COUNT == 0: COUNT SHALL become LIMIT if SAT=0, or stay 0 if SAT=1, and TRIG_UNDER SHALL be 1 on the following cycle.
REQ-023 Each trigger SHALL be high for exactly one cycle per qualifying step; back-to-back qualifying steps SHALL keep the trigger high continuously.
REQ-024 With ENABLE=0 and LOAD=0, COUNT SHALL hold and both triggers SHALL be 0 on the next cycle.
REQ-025 With LIMIT == 0, COUNT SHALL remain 0; an up-step SHALL fire TRIG_OUT and a down-step SHALL fire TRIG_UNDER.
REQ-026 TRIG_OUT and TRIG_UNDER SHALL never be high in the same cycle.
REQ-027 All arithmetic SHALL be unsigned at COUNTER_WIDTH bits; COUNT SHALL never exceed LIMIT except when LIMIT is lowered below it, until the next step or load.

Reset
REQ-028 RESET high at a rising edge SHALL set COUNT to RESET_VALUE and TRIG_OUT and TRIG_UNDER to 0, overriding LOAD and ENABLE.
REQ-029 Reset asserted mid-count SHALL cancel any trigger pending from that cycle's step.
REQ-030 Counting SHALL resume on the first edge with RESET low; RESET_VALUE is not clamped to LIMIT.

Configuration
REQ-031 Macro UPDOWN_LIMIT_COUNTER_SAT_EN defined: SAT behaves as specified in REQ-019 and REQ-022.
REQ-032 Macro UPDOWN_LIMIT_COUNTER_SAT_EN undefined: the SAT port SHALL remain present but be ignored, the block SHALL always wrap, and no saturation logic SHALL be synthesised.

Verification
REQ-033 W=4, LIMIT=9, SAT=0, UP=1, ENABLE held high for 12 cycles -> COUNT 0..9,0,1; TRIG_OUT high only in the cycle after COUNT=9.
REQ-034 LIMIT=9, SAT=0, UP=0 from COUNT=0 for 3 enabled cycles -> COUNT 9,8,7; TRIG_UNDER high for exactly one cycle after the first step.
REQ-035 SAT=1 (macro defined), LIMIT=5, COUNT=5, UP=1, ENABLE high for 3 cycles -> COUNT stays 5; TRIG_OUT high for 3 consecutive cycles.
REQ-036 LOAD_VALUE=12, LIMIT=9, LOAD=1 and ENABLE=1 together -> COUNT=9, no trigger; then LIMIT=3 with UP=0 -> COUNT=3.
REQ-037 RESET=1 asserted in the same cycle as an up-step at COUNT=LIMIT, RESET_VALUE=2 -> COUNT=2 and TRIG_OUT=0 on the next cycle.
